bus_byte_sequencer: RTL and testbench

BUS_BYTE_SEQUENCER -- requirements
Module: bus_byte_sequencer

---
 rtl/bus_byte_sequencer_if.sv | 31 +++
 rtl/bus_byte_sequencer.sv | 110 +++++++++++
 tb/tb_bus_byte_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_byte_sequencer_if.sv
// Request/response handshake and byte-wide external bus of the byte sequencer.
// master = CPU/memory side, slave = sequencer side.
interface bus_byte_sequencer_if #(
   parameter int ADDRESS_WIDTH = 8
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [1:0]               req_size;
   logic [ADDRESS_WIDTH-1:0] req_address;
   logic [31:0]              req_write_data;
   logic                     resp_valid;
   logic [31:0]              resp_read_data;
   logic                     resp_error;
   logic [ADDRESS_WIDTH-1:0] bus_address;
   logic                     bus_write_enable;
   logic [7:0]               bus_write_data;
   logic [7:0]               bus_read_data;

   modport master (
      output req_valid, req_write, req_size, req_address, req_write_data, bus_read_data,
      input  req_ready, resp_valid, resp_read_data, resp_error,
             bus_address, bus_write_enable, bus_write_data
   );

   modport slave (
      input  req_valid, req_write, req_size, req_address, req_write_data, bus_read_data,
      output req_ready, resp_valid, resp_read_data, resp_error,
             bus_address, bus_write_enable, bus_write_data
   );
endinterface

// File: rtl/bus_byte_sequencer.sv
// Splits byte/halfword/word CPU requests into one-byte-per-cycle bus accesses.
// Optional MISALIGN_CHECK_EN rejects misaligned halfword/word requests with resp_error.
//
// state | meaning
// IDLE  | ready for a request; bus quiet
// XFER  | one bus byte per cycle, counter selects the byte lane
// RESP  | one-cycle completion pulse, read data held afterwards
module bus_byte_sequencer #(
   parameter int ADDRESS_WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   bus_byte_sequencer_if.slave  sif
);
   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t                   state_q, state_d;
   logic [1:0]               cnt_q;
   logic                     wr_q;
   logic [1:0]               size_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [31:0]              wdata_q;
   logic [31:0]              rdata_q;
   logic [1:0]               last_cnt;
   logic [7:0]               wbyte;
   logic                     handshake;
   logic                     misalign;
   logic                     in_xfer;

   assign handshake = sif.req_valid && (state_q == IDLE);
   assign in_xfer   = (state_q == XFER);

`ifdef MISALIGN_CHECK_EN
   logic err_q;
   assign misalign = ((sif.req_size == 2'b01) && sif.req_address[0]) ||
                     (sif.req_size[1] && (sif.req_address[1:0] != 2'b00));
   assign sif.resp_error = (state_q == RESP) && err_q;
`else
   assign misalign = 1'b0;
   assign sif.resp_error = 1'b0;
`endif

   always_comb begin
      case (size_q)
         2'b00:   last_cnt = 2'd0;
         2'b01:   last_cnt = 2'd1;
         default: last_cnt = 2'd3;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (handshake) state_d = misalign ? RESP : XFER;
         XFER: if (cnt_q == last_cnt) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef MISALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else if (handshake) begin
         cnt_q   <= '0;
         wr_q    <= sif.req_write;
         size_q  <= sif.req_size;
         addr_q  <= sif.req_address;
         wdata_q <= sif.req_write_data;
         rdata_q <= '0;
`ifdef MISALIGN_CHECK_EN
         err_q   <= misalign;
`endif
      end else if (in_xfer) begin
         cnt_q <= cnt_q + 2'd1;
         if (!wr_q) rdata_q[8*cnt_q +: 8] <= sif.bus_read_data;
      end
   end

   always_comb begin
      case (cnt_q)
         2'd0:    wbyte = wdata_q[7:0];
         2'd1:    wbyte = wdata_q[15:8];
         2'd2:    wbyte = wdata_q[23:16];
         default: wbyte = wdata_q[31:24];
      endcase
   end

   // Bus strobes decode from the async-reset state so a reset drops them at once.
   assign sif.bus_address      = in_xfer ? addr_q + ADDRESS_WIDTH'(cnt_q) : '0;
   assign sif.bus_write_enable = in_xfer && wr_q;
   assign sif.bus_write_data   = (in_xfer && wr_q) ? wbyte : 8'h00;

   assign sif.req_ready      = (state_q == IDLE);
   assign sif.resp_valid     = (state_q == RESP);
   assign sif.resp_read_data = rdata_q;
endmodule

// File: tb/tb_bus_byte_sequencer.sv
// Directed bench for bus_byte_sequencer with a byte-wide memory model on the bus.
module tb_bus_byte_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   bus_byte_sequencer_if #(.ADDRESS_WIDTH(8)) ifc ();

   bus_byte_sequencer #(.ADDRESS_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (ifc)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   bit         init_done = 1'b0;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
         mem[8'h20] <= 8'h9C;
         mem[8'hFF] <= 8'h34;
         mem[8'h00] <= 8'h12;
         init_done  <= 1'b1;
      end else if (ifc.bus_write_enable) begin
         mem[ifc.bus_address] <= ifc.bus_write_data;
      end
   end

   assign ifc.bus_read_data = mem[ifc.bus_address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble req_* during XFER, check every bus cycle and the response.
   task automatic xfer(input string tag, input logic w, input logic [1:0] sz,
                       input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
      int n;
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      @(negedge clk);
      ifc.req_valid = 1'b1; ifc.req_write = w; ifc.req_size = sz;
      ifc.req_address = a; ifc.req_write_data = wd;
      chk({tag, " ready_idle"}, 32'(ifc.req_ready), 32'd1);
      @(posedge clk); #1;
      ifc.req_valid = 1'b0; ifc.req_write = ~w; ifc.req_size = ~sz;
      ifc.req_address = ~a; ifc.req_write_data = ~wd;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk({tag, " addr"},  32'(ifc.bus_address), 32'(8'(a + 8'(k))));
         chk({tag, " we"},    32'(ifc.bus_write_enable), 32'(w));
         chk({tag, " wdata"}, 32'(ifc.bus_write_data), w ? ((wd >> (8*k)) & 32'hFF) : 32'h0);
         chk({tag, " ready_xfer"}, 32'(ifc.req_ready), 32'd0);
         chk({tag, " resp_xfer"},  32'(ifc.resp_valid), 32'd0);
      end
      @(negedge clk);
      chk({tag, " resp_valid"}, 32'(ifc.resp_valid), 32'd1);
      chk({tag, " resp_data"},  ifc.resp_read_data, exp_rd);
      chk({tag, " resp_err"},   32'(ifc.resp_error), 32'd0);
      chk({tag, " ready_resp"}, 32'(ifc.req_ready), 32'd0);
      chk({tag, " we_resp"},    32'(ifc.bus_write_enable), 32'd0);
      chk({tag, " addr_resp"},  32'(ifc.bus_address), 32'd0);
      @(negedge clk);
      chk({tag, " resp_drop"},  32'(ifc.resp_valid), 32'd0);
      chk({tag, " ready_back"}, 32'(ifc.req_ready), 32'd1);
      chk({tag, " data_hold"},  ifc.resp_read_data, exp_rd);
   endtask

`ifdef MISALIGN_CHECK_EN
   task automatic xfer_misaligned(input string tag, input logic w, input logic [1:0] sz,
                                  input logic [7:0] a);
      @(negedge clk);
      ifc.req_valid = 1'b1; ifc.req_write = w; ifc.req_size = sz;
      ifc.req_address = a; ifc.req_write_data = 32'hCAFEF00D;
      @(posedge clk); #1;
      ifc.req_valid = 1'b0;
      @(negedge clk);
      chk({tag, " resp_valid"}, 32'(ifc.resp_valid), 32'd1);
      chk({tag, " resp_err"},   32'(ifc.resp_error), 32'd1);
      chk({tag, " resp_data"},  ifc.resp_read_data, 32'h0);
      chk({tag, " we"},         32'(ifc.bus_write_enable), 32'd0);
      chk({tag, " addr"},       32'(ifc.bus_address), 32'd0);
      @(negedge clk);
      chk({tag, " err_drop"},   32'(ifc.resp_error), 32'd0);
      chk({tag, " ready_back"}, 32'(ifc.req_ready), 32'd1);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] exp_ready;
      logic [17:0] exp_resp;
      logic [31:0] exp_rd [4];
      int          idx;
      int          ridx;
      logic        hs;

      rst_n = 1'b0;
      ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_size = 2'b00;
      ifc.req_address = 8'h00; ifc.req_write_data = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst resp_valid", 32'(ifc.resp_valid), 32'd0);
      chk("rst resp_err",   32'(ifc.resp_error), 32'd0);
      chk("rst we",         32'(ifc.bus_write_enable), 32'd0);
      chk("rst addr",       32'(ifc.bus_address), 32'd0);
      chk("rst wdata",      32'(ifc.bus_write_data), 32'd0);
      chk("rst rdata",      ifc.resp_read_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst ready", 32'(ifc.req_ready), 32'd1);

      xfer("word_store", 1'b1, 2'b10, 8'h10, 32'hDEADBEEF, 32'h0);
      chk("mem 0x10", 32'(mem[8'h10]), 32'hEF);
      chk("mem 0x13", 32'(mem[8'h13]), 32'hDE);
      xfer("byte_load", 1'b0, 2'b00, 8'h20, 32'h0, 32'h0000009C);
      xfer("word_load", 1'b0, 2'b10, 8'h10, 32'h0, 32'hDEADBEEF);
      xfer("half_store", 1'b1, 2'b01, 8'h50, 32'h1234ABCD, 32'h0);
      xfer("half_load", 1'b0, 2'b01, 8'h50, 32'h0, 32'h0000ABCD);
      xfer("size11_load", 1'b0, 2'b11, 8'h10, 32'h0, 32'hDEADBEEF);
`ifdef MISALIGN_CHECK_EN
      xfer_misaligned("half_wrap_err", 1'b0, 2'b01, 8'hFF);
      xfer_misaligned("word_wrap_err", 1'b1, 2'b10, 8'hFE);
      chk("mem 0xFE untouched", 32'(mem[8'hFE]), 32'(8'hFE ^ 8'hA5));
`else
      xfer("half_wrap_load", 1'b0, 2'b01, 8'hFF, 32'h0, 32'h00001234);
      xfer("word_wrap_store", 1'b1, 2'b10, 8'hFE, 32'h11223344, 32'h0);
      xfer("word_wrap_load", 1'b0, 2'b10, 8'hFE, 32'h0, 32'h11223344);
`endif

      // Reset during the second byte of a word store.
      @(negedge clk);
      ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_size = 2'b10;
      ifc.req_address = 8'h30; ifc.req_write_data = 32'h87654321;
      @(posedge clk); #1;
      ifc.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort pre addr", 32'(ifc.bus_address), 32'h31);
      chk("abort pre we",   32'(ifc.bus_write_enable), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort we",    32'(ifc.bus_write_enable), 32'd0);
      chk("abort addr",  32'(ifc.bus_address), 32'd0);
      chk("abort resp",  32'(ifc.resp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort ready", 32'(ifc.req_ready), 32'd1);
      chk("abort resp_after", 32'(ifc.resp_valid), 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("abort no_resp", 32'(ifc.resp_valid), 32'd0);
      end
      chk("abort mem 0x32", 32'(mem[8'h32]), 32'(8'h32 ^ 8'hA5));

      // Back-to-back with req_valid held high: store byte, load word, store byte, load word.
      exp_ready = 18'b0; exp_ready[0] = 1'b1; exp_ready[3] = 1'b1;
      exp_ready[9] = 1'b1; exp_ready[12] = 1'b1;
      exp_resp = 18'b0; exp_resp[2] = 1'b1; exp_resp[8] = 1'b1;
      exp_resp[11] = 1'b1; exp_resp[17] = 1'b1;
      exp_rd[0] = 32'h0; exp_rd[1] = 32'hE6E7E455;
      exp_rd[2] = 32'h0; exp_rd[3] = 32'hE6E7E466;
      idx = 0; ridx = 0;
      @(negedge clk);
      ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_size = 2'b00;
      ifc.req_address = 8'h40; ifc.req_write_data = 32'h00000055;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("b2b ready c%0d", c), 32'(ifc.req_ready), 32'(exp_ready[c]));
         chk($sformatf("b2b resp c%0d", c),  32'(ifc.resp_valid), 32'(exp_resp[c]));
         if (ifc.resp_valid) begin
            if (ridx < 4) chk($sformatf("b2b rdata r%0d", ridx), ifc.resp_read_data, exp_rd[ridx]);
            ridx++;
         end
         hs = ifc.req_ready && ifc.req_valid;
         @(posedge clk); #1;
         if (hs) begin
            idx++;
            if (idx >= 4) ifc.req_valid = 1'b0;
            else if (idx[0]) begin
               ifc.req_write = 1'b0; ifc.req_size = 2'b10;
               ifc.req_address = 8'h40; ifc.req_write_data = 32'h0;
            end else begin
               ifc.req_write = 1'b1; ifc.req_size = 2'b00;
               ifc.req_address = 8'h40; ifc.req_write_data = 32'h00000066;
            end
         end
      end
      chk("b2b accepted", 32'(idx), 32'd4);
      chk("b2b responses", 32'(ridx), 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
